alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-port round-robin controller that shares the single 8-bit `alu` instance between the instruction pipeline (port 0) and the peripheral/timer sequencer (port 1). It latches a requester's opcode and operands and drives the ALU's `aluEn`/opcode/operand inputs for exactly one cycle. It captures `aluOut`/`carryOut` into a result register and returns a one-cycle done pulse to the granted requester. It sits between the requesters and the `alu` and is the only block allowed to drive the ALU inputs.

## Interface
- `OPW`, default `` `aluOpcodeLen ``: ALU opcode width.
- `clk` in 1: the only clock; everything updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req0`, `req1` in 1 each: level request from port 0 / port 1. Held high until the matching `done`.
- `opc0`, `opc1` in OPW each: requested ALU opcode.
- `a0`, `b0`, `a1`, `b1` in 8 each: op1 / op2 operands per port.
- `grant0`, `grant1` out 1 each: one-hot; high while that port's operation executes.
- `done0`, `done1` out 1 each: one-cycle pulse; `result`/`resCarry` are valid in the same cycle.
- `result` out 8: registered ALU result.
- `resCarry` out 1: registered carry. Equals ALU `carryOut` for `ADD_alu`/`SUB_alu`; 0 for every other opcode.
- `busy` out 1: high in the EXEC and DONE states.
- `aluOpcode` out OPW: to the ALU.
- `aluOp1`, `aluOp2` out 8: to the ALU.
- `aluEn` out 1: to the ALU.
- `aluOut` in 8: from the ALU.
- `carryOut` in 1: from the ALU.

## Operation
- FSM states are IDLE, EXEC and DONE. Transitions are IDLE→EXEC→DONE→IDLE.
- **IDLE**
  - Sample `req0`/`req1`. If neither is high, stay in IDLE.
  - If exactly one is high, select that port.
  - If both are high, select the port that is not `last`, where `last` is the most recently served port. After reset, `last` = 1, so port 0 wins the first tie.
  - On selection: latch that port's opc/a/b into internal registers, record the selected port in `sel`, go to EXEC.
- **EXEC**
  - `grant[sel]` = 1 and `aluEn` = 1.
  - `aluOpcode`/`aluOp1`/`aluOp2` are driven from the latched registers.
  - At the end of the cycle: `result` ← `aluOut`, `resCarry` ← (latched opc is ADD/SUB) ? `carryOut` : 0, `last` ← `sel`. Go to DONE.
- **DONE**
  - `done[sel]` = 1 and `aluEn` = 0. `result` and `resCarry` hold. Go to IDLE.
- Outside EXEC:
  - `aluEn` = 0.
  - `aluOp1`, `aluOp2` and `aluOpcode` are all 0.
  - This keeps the ALU, which holds its output when disabled, quiescent.
- Requester input changes after IDLE sampling are ignored; the operands are latched.
- A requester drops its `req` in the cycle after its `done` pulse.
  - If `req` is still high when IDLE samples it, that counts as a new request with the current inputs.
  - Round-robin still applies, so a competing port is served first.
- If `req[sel]` drops during EXEC or DONE, the operation still completes and `done[sel]` still pulses. The result is simply unused.
- An unknown opcode is passed through unchanged. The ALU returns 0, and `result` = 0, `resCarry` = 0.
- **Reset** (`reset` = 0 at a rising edge), from any state including mid-EXEC:
  - Next state is IDLE, `last` = 1.
  - `result` = 0, `resCarry` = 0, all latched registers = 0.
  - All outputs are 0: `grant*`, `done*`, `busy`, `aluEn`, `aluOpcode`, `aluOp1`, `aluOp2`.
  - No `done` is issued for an operation aborted by reset.

## Timing
- Latency: a request seen in IDLE at edge N produces grant in cycle N+1 and `done` in cycle N+2. The FSM is back in IDLE at N+3.
- Throughput: at most one operation every 3 cycles. With both ports continuously requesting, they alternate 0,1,0,1.
- `grant*`, `done*`, `busy`, `aluEn` and the ALU input buses are decoded from registered state only. There is no combinational path from `req*` to any output.
- `result` changes only at the EXEC→DONE edge and on reset.

## Test plan
- Reset then single request: `req0`=1, ADD_alu, a0=8'hF0, b0=8'h20.
  - Required: `grant0` high in cycle 1, `done0` in cycle 2, `result`=8'h10, `resCarry`=1, `grant1`/`done1` never assert.
- Simultaneous first request: `req0`=`req1`=1 right after reset.
  - Required: port 0 served first, then port 1.
  - Port 1 runs SUB_alu, 8'h05−8'h06: `result`=8'hFF, `resCarry`=1.
- Continuous contention: both ports request for 12 cycles.
  - Required: `done0`/`done1` alternate every 3 cycles, 4 operations total, never the same port twice in a row.
- Operand change after grant: port 1 runs AND_alu with a1=8'hCC, b1=8'hAA, and a1 is set to 8'h00 during EXEC.
  - Required: `result`=8'h88, `resCarry`=0.
- Reset mid-EXEC: assert `reset`=0 during EXEC.
  - Required: the next cycle has all outputs 0, no `done` pulse, and the next tie goes to port 0.
- Carry masking: ADD_alu 8'hFF+8'h01 (`resCarry`=1), followed by GT_alu 8'h03>8'h02.
  - Required: second result has `result`=8'h01 and `resCarry`=0.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter that shares the single 8-bit ALU
// between the instruction pipeline (port 0) and the peripheral/timer
// sequencer (port 1). Each operation runs IDLE -> EXEC -> DONE. Every
// output is a register, so there is no combinational path from req* to
// any output.
//
// Handshake: a requester raises reqN with stable opcN/aN/bN and holds it
// until doneN pulses for one cycle, when result/resCarry are valid. The
// operands are captured on the IDLE edge that grants the port, so later
// changes to them are ignored. A req still high when IDLE samples it again
// counts as a new request.

`ifndef aluOpcodeLen
`define aluOpcodeLen 4
`endif
`ifndef ADD_alu
`define ADD_alu 0
`endif
`ifndef SUB_alu
`define SUB_alu 1
`endif

module alu_share_ctrl #(
    parameter int OPW = `aluOpcodeLen
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0,
    input  logic           req1,
    input  logic [OPW-1:0] opc0,
    input  logic [OPW-1:0] opc1,
    input  logic [7:0]     a0,
    input  logic [7:0]     b0,
    input  logic [7:0]     a1,
    input  logic [7:0]     b1,
    output logic           grant0,
    output logic           grant1,
    output logic           done0,
    output logic           done1,
    output logic [7:0]     result,
    output logic           resCarry,
    output logic           busy,
    output logic [OPW-1:0] aluOpcode,
    output logic [7:0]     aluOp1,
    output logic [7:0]     aluOp2,
    output logic           aluEn,
    input  logic [7:0]     aluOut,
    input  logic           carryOut,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic           last_q;
    logic           sel_q;
    logic           grant0_q, grant1_q;
    logic           done0_q, done1_q;
    logic           busy_q;
    logic           alu_en_q;
    logic [OPW-1:0] alu_opc_q;
    logic [7:0]     alu_op1_q, alu_op2_q;
    logic [7:0]     result_q;
    logic           res_carry_q;

    logic           any_req_d;
    logic           pick1_d;
    logic           op_arith_d;

    // Port pick: a lone requester wins; on a tie the port that was not served last wins.
    always_comb begin
        any_req_d  = req0 | req1;
        pick1_d    = req1 & (~req0 | ~last_q);
        op_arith_d = (alu_opc_q == OPW'(`ADD_alu)) || (alu_opc_q == OPW'(`SUB_alu));
    end

    // Control FSM. The operand buses double as the latched request and are
    // cleared outside EXEC so the ALU stays quiescent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_opc_q   <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            result_q    <= '0;
            res_carry_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (any_req_d) begin
                        sel_q     <= pick1_d;
                        grant0_q  <= ~pick1_d;
                        grant1_q  <= pick1_d;
                        busy_q    <= 1'b1;
                        alu_en_q  <= 1'b1;
                        alu_opc_q <= pick1_d ? opc1 : opc0;
                        alu_op1_q <= pick1_d ? a1 : a0;
                        alu_op2_q <= pick1_d ? b1 : b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q    <= aluOut;
                    res_carry_q <= op_arith_d ? carryOut : 1'b0;
                    last_q      <= sel_q;
                    grant0_q    <= 1'b0;
                    grant1_q    <= 1'b0;
                    alu_en_q    <= 1'b0;
                    alu_opc_q   <= '0;
                    alu_op1_q   <= '0;
                    alu_op2_q   <= '0;
                    done0_q     <= ~sel_q;
                    done1_q     <= sel_q;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant0_q  <= 1'b0;
                    grant1_q  <= 1'b0;
                    done0_q   <= 1'b0;
                    done1_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    alu_en_q  <= 1'b0;
                    alu_opc_q <= '0;
                    alu_op1_q <= '0;
                    alu_op2_q <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign grant0    = grant0_q;
    assign grant1    = grant1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign busy      = busy_q;
    assign aluEn     = alu_en_q;
    assign aluOpcode = alu_opc_q;
    assign aluOp1    = alu_op1_q;
    assign aluOp2    = alu_op2_q;
    assign result    = result_q;
    assign resCarry  = res_carry_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU and a scoreboard
// that checks every done pulse against the next expected {port, carry, result}.

module tb_alu_share_ctrl;

    localparam int OPW = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_GT  = 4'd6;
    localparam logic [3:0] OP_BAD = 4'hF;

    logic           clk;
    logic           reset;
    logic           req0, req1;
    logic [OPW-1:0] opc0, opc1;
    logic [7:0]     a0, b0, a1, b1;
    logic           grant0, grant1, done0, done1;
    logic [7:0]     result;
    logic           resCarry, busy;
    logic [OPW-1:0] aluOpcode;
    logic [7:0]     aluOp1, aluOp2;
    logic           aluEn;
    logic [7:0]     aluOut;
    logic           carryOut;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    int n_done;
    logic [9:0] exp_q[$];
    logic [9:0] exp_ent;

    alu_share_ctrl #(.OPW(OPW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .opc0(opc0), .opc1(opc1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
        .result(result), .resCarry(resCarry), .busy(busy),
        .aluOpcode(aluOpcode), .aluOp1(aluOp1), .aluOp2(aluOp2), .aluEn(aluEn),
        .aluOut(aluOut), .carryOut(carryOut), .dbg_state(dbg_state)
    );

    // Behavioural ALU: non-arithmetic ops drive a junk carry of 1 so the
    // controller's carry masking is observable.
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b1, a & b};
            OP_GT:   return {1'b1, 7'd0, (a > b)};
            default: return 9'h100;
        endcase
    endfunction

    logic [8:0] alu_now;
    logic [8:0] alu_hold = 9'h000;
    assign alu_now  = alu_ref(aluOpcode, aluOp1, aluOp2);
    assign aluOut   = aluEn ? alu_now[7:0] : alu_hold[7:0];
    assign carryOut = aluEn ? alu_now[8]   : alu_hold[8];
    always @(posedge clk) if (aluEn) alu_hold <= alu_now;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic [7:0] res, input logic c);
        exp_q.push_back({port, c, res});
    endtask

    task automatic run_single(input logic port, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] eres, input logic ec);
        push(port, eres, ec);
        if (port == 1'b0) begin
            req0 = 1'b1; opc0 = op; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; opc1 = op; a1 = a; b1 = b;
        end
        tick();
        chk("grant_cycle", {grant0, grant1, aluEn, busy}, port ? 4'b0111 : 4'b1011);
        chk("alu_bus", {aluOpcode, aluOp1, aluOp2}, {op, a, b});
        tick();
        chk("done_cycle", {done0, done1, grant0, grant1, aluEn, busy},
            port ? 6'b010001 : 6'b100001);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Scoreboard: each done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && (done0 || done1)) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_done: observed done0=%0b done1=%0b expected none", done0, done1);
            end
            if (exp_q.size() > 0) begin
                exp_ent = exp_q.pop_front();
                chk("sb_result", {done0, done1, resCarry, result},
                    {~exp_ent[9], exp_ent[9], exp_ent[8], exp_ent[7:0]});
            end
        end
    end

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        opc0 = '0; opc1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        chk("reset_outputs", {grant0, grant1, done0, done1, busy, aluEn, aluOpcode,
                              aluOp1, aluOp2, result, resCarry}, 64'd0);
        chk("reset_state", dbg_state, 2'd0);
        reset = 1'b1;
        tick();
        chk("idle_quiet", {busy, aluEn, grant0, grant1, done0, done1}, 6'd0);

        // Single request on port 0: F0 + 20 -> 10 with carry.
        run_single(1'b0, OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1);
        tick();
        chk("result_hold", {result, resCarry, busy}, {8'h10, 1'b1, 1'b0});

        // Simultaneous first request after reset: port 0 then port 1.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        push(1'b0, 8'h05, 1'b0);
        push(1'b1, 8'hFF, 1'b1);
        req0 = 1'b1; opc0 = OP_ADD; a0 = 8'h02; b0 = 8'h03;
        req1 = 1'b1; opc1 = OP_SUB; a1 = 8'h05; b1 = 8'h06;
        tick();
        chk("first_tie_grant", {grant0, grant1}, 2'b10);
        tick();
        chk("first_tie_done0", {done0, done1}, 2'b10);
        tick();
        req0 = 1'b0;
        tick();
        chk("second_grant", {grant0, grant1}, 2'b01);
        tick();
        chk("second_done1", {done0, done1, result, resCarry}, {2'b01, 8'hFF, 1'b1});
        tick();
        req1 = 1'b0;

        // Continuous contention for 12 cycles: 0,1,0,1 every 3 cycles.
        push(1'b0, 8'h30, 1'b0);
        push(1'b1, 8'hF0, 1'b1);
        push(1'b0, 8'h30, 1'b0);
        push(1'b1, 8'hF0, 1'b1);
        req0 = 1'b1; opc0 = OP_ADD; a0 = 8'h10; b0 = 8'h20;
        req1 = 1'b1; opc1 = OP_SUB; a1 = 8'h10; b1 = 8'h20;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 || done1) n_done++;
            chk("contention_done_pattern", {done0, done1},
                (i % 3 == 1) ? (((i / 3) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("contention_count", n_done, 4);

        // Operand change during EXEC is ignored.
        push(1'b1, 8'h88, 1'b0);
        req1 = 1'b1; opc1 = OP_AND; a1 = 8'hCC; b1 = 8'hAA;
        tick();
        chk("opchg_grant", {grant0, grant1}, 2'b01);
        a1 = 8'h00;
        tick();
        chk("opchg_result", {done1, result, resCarry}, {1'b1, 8'h88, 1'b0});
        tick();
        req1 = 1'b0;

        // Serve port 0 so the last-served port is 0, then abort port 1 by reset.
        run_single(1'b0, OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0);
        req1 = 1'b1; opc1 = OP_SUB; a1 = 8'h09; b1 = 8'h01;
        tick();
        chk("abort_grant", {grant0, grant1, aluEn}, 3'b011);
        reset = 1'b0;
        req1 = 1'b0;
        tick();
        chk("midexec_reset_outputs", {grant0, grant1, done0, done1, busy, aluEn, aluOpcode,
                                      aluOp1, aluOp2, result, resCarry}, 64'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("no_done_after_abort", {done0, done1, busy}, 3'd0);

        // Tie after reset goes to port 0; carry masking ADD then GT.
        push(1'b0, 8'h00, 1'b1);
        push(1'b1, 8'h01, 1'b0);
        req0 = 1'b1; opc0 = OP_ADD; a0 = 8'hFF; b0 = 8'h01;
        req1 = 1'b1; opc1 = OP_GT;  a1 = 8'h03; b1 = 8'h02;
        tick();
        chk("tie_after_reset", {grant0, grant1}, 2'b10);
        tick();
        chk("add_carry", {done0, result, resCarry}, {1'b1, 8'h00, 1'b1});
        tick();
        req0 = 1'b0;
        tick();
        chk("gt_grant", {grant0, grant1}, 2'b01);
        tick();
        chk("gt_carry_masked", {done1, result, resCarry}, {1'b1, 8'h01, 1'b0});
        tick();
        req1 = 1'b0;

        // Unknown opcode passes through; ALU returns 0 and carry is masked.
        run_single(1'b0, OP_BAD, 8'h12, 8'h34, 8'h00, 1'b0);
        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
